// File: rtl/debounce_multi.sv
// Multi-channel debouncer: per-channel synchroniser, qualification FSM and
// registered level / rise / fall outputs. Channels share nothing but clk and reset.
module debounce_multi #(
    parameter int N_CHANNELS      = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_CHANNELS-1:0]     noisy,
    output logic [N_CHANNELS-1:0]     debounced,
    output logic [N_CHANNELS-1:0]     rise,
    output logic [N_CHANNELS-1:0]     fall,
    output logic [2*N_CHANNELS-1:0]   state_dbg
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   s;
        state_t                 state;
        state_t                 state_nx;
        logic [CW-1:0]          cnt;
        logic [CW-1:0]          cnt_nx;
        logic                   level;
        logic                   deb_r;
        logic                   rise_r;
        logic                   fall_r;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync <= '0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], noisy[i]};
            end
        end

        assign s = sync[SYNC_STAGES-1];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state <= STABLE_LO;
                cnt   <= '0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
            end
        end

        // Counter is zero everywhere except while a PEND state keeps counting.
        always_comb begin
            state_nx = state;
            cnt_nx   = '0;
            case (state)
                STABLE_LO: if (s) state_nx = PEND_HI;
                PEND_HI: begin
                    if (!s)                  state_nx = STABLE_LO;
                    else if (cnt == CNT_MAX) state_nx = STABLE_HI;
                    else                     cnt_nx   = cnt + CW'(1);
                end
                STABLE_HI: if (!s) state_nx = PEND_LO;
                PEND_LO: begin
                    if (s)                   state_nx = STABLE_HI;
                    else if (cnt == CNT_MAX) state_nx = STABLE_LO;
                    else                     cnt_nx   = cnt + CW'(1);
                end
                default: state_nx = STABLE_LO;
            endcase
        end

        assign level = (state == STABLE_HI) || (state == PEND_LO);

        // Edge pulses come from the same register stage as the level, so a
        // pulse lines up with the first cycle the new level is visible.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                deb_r  <= 1'b0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                deb_r  <= level;
                rise_r <= level & ~deb_r;
                fall_r <= ~level & deb_r;
            end
        end

        assign debounced[i]       = deb_r;
        assign rise[i]            = rise_r;
        assign fall[i]            = fall_r;
        assign state_dbg[2*i +: 2] = state;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: 4-channel instance with a 4-cycle
// qualification window plus a 1-channel instance with the minimum window.
module tb_debounce_multi;

    logic       clk;
    logic       reset_n;
    logic [3:0] noisy;
    logic [3:0] debounced;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [7:0] state_dbg;

    logic [0:0] noisy1;
    logic [0:0] debounced1;
    logic [0:0] rise1;
    logic [0:0] fall1;
    logic [1:0] state_dbg1;

    int n_cmp = 0;
    int n_err = 0;

    debounce_multi #(
        .N_CHANNELS(4), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .noisy(noisy),
        .debounced(debounced), .rise(rise), .fall(fall), .state_dbg(state_dbg)
    );

    debounce_multi #(
        .N_CHANNELS(1), .DEBOUNCE_CYCLES(1), .SYNC_STAGES(2)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .noisy(noisy1),
        .debounced(debounced1), .rise(rise1), .fall(fall1), .state_dbg(state_dbg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1ns past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        noisy   = 4'b0000;
        noisy1  = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({debounced, rise, fall, state_dbg} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_async: got %h required 00000", {debounced, rise, fall, state_dbg});
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            tick();
            n_cmp++;
            if ({debounced, rise, fall} !== 12'h000) begin
                n_err++;
                $display("FAIL idle_low tick %0d: deb=%b rise=%b fall=%b required all 0",
                         j, debounced, rise, fall);
            end
        end
    endtask

    task automatic test_step();
        logic [3:0] e_deb, e_rise;
        noisy = 4'b0001;
        for (int j = 1; j <= 10; j++) begin
            tick();
            e_deb  = (j >= 8) ? 4'b0001 : 4'b0000;
            e_rise = (j == 8) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if ({debounced, rise, fall} !== {e_deb, e_rise, 4'b0000}) begin
                n_err++;
                $display("FAIL step_ch0 tick %0d: deb=%b rise=%b fall=%b required %b %b 0000",
                         j, debounced, rise, fall, e_deb, e_rise);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] e_deb, e_rise, e_fall;
        // Four samples high: one short of acceptance.
        noisy = 4'b0011;
        for (int j = 1; j <= 14; j++) begin
            tick();
            if (j == 4) noisy = 4'b0001;
            n_cmp++;
            if ({debounced, rise, fall} !== {4'b0001, 4'b0000, 4'b0000}) begin
                n_err++;
                $display("FAIL glitch_short tick %0d: deb=%b rise=%b fall=%b required 0001 0000 0000",
                         j, debounced, rise, fall);
            end
        end
        // Five samples high: accepted, then released.
        noisy = 4'b0011;
        for (int j = 1; j <= 16; j++) begin
            tick();
            if (j == 5) noisy = 4'b0001;
            e_deb  = 4'b0001 | ((j >= 8 && j < 13) ? 4'b0010 : 4'b0000);
            e_rise = (j == 8)  ? 4'b0010 : 4'b0000;
            e_fall = (j == 13) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if ({debounced, rise, fall} !== {e_deb, e_rise, e_fall}) begin
                n_err++;
                $display("FAIL pulse_5 tick %0d: deb=%b rise=%b fall=%b required %b %b %b",
                         j, debounced, rise, fall, e_deb, e_rise, e_fall);
            end
        end
    endtask

    task automatic test_toggle();
        logic [3:0] e_deb, e_rise;
        for (int j = 1; j <= 36; j++) begin
            noisy[2] = (j <= 20) ? ((((j - 1) / 2) % 2) == 0) : 1'b1;
            tick();
            e_deb  = 4'b0001 | ((j >= 28) ? 4'b0100 : 4'b0000);
            e_rise = (j == 28) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if ({debounced, rise, fall} !== {e_deb, e_rise, 4'b0000}) begin
                n_err++;
                $display("FAIL toggle_ch2 tick %0d: deb=%b rise=%b fall=%b required %b %b 0000",
                         j, debounced, rise, fall, e_deb, e_rise);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e_deb, e_rise, e_fall;
        noisy = 4'b1100;
        for (int j = 1; j <= 10; j++) begin
            tick();
            e_deb  = (j >= 8) ? 4'b1100 : 4'b0101;
            e_rise = (j == 8) ? 4'b1000 : 4'b0000;
            e_fall = (j == 8) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if ({debounced, rise, fall} !== {e_deb, e_rise, e_fall}) begin
                n_err++;
                $display("FAIL simultaneous tick %0d: deb=%b rise=%b fall=%b required %b %b %b",
                         j, debounced, rise, fall, e_deb, e_rise, e_fall);
            end
        end
    endtask

    task automatic test_min_count();
        noisy1 = 1'b1;
        tick();
        noisy1 = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            n_cmp++;
            if ({debounced1, rise1, fall1} !== 3'b000) begin
                n_err++;
                $display("FAIL min_glitch tick %0d: deb=%b rise=%b fall=%b required 0 0 0",
                         j, debounced1, rise1, fall1);
            end
        end
        noisy1 = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            tick();
            n_cmp++;
            if ({debounced1, rise1, fall1} !== {(j >= 5), (j == 5), 1'b0}) begin
                n_err++;
                $display("FAIL min_accept tick %0d: deb=%b rise=%b fall=%b required %b %b 0",
                         j, debounced1, rise1, fall1, (j >= 5), (j == 5));
            end
        end
    endtask

    task automatic test_reset_mid();
        noisy = 4'b1111;
        for (int j = 1; j <= 4; j++) tick();
        // Channels 0/1 are mid-PEND_HI, 2/3 are STABLE_HI; assert between edges.
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({debounced, rise, fall, state_dbg} !== 20'h0 || {debounced1, rise1, fall1} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid: deb=%b rise=%b fall=%b st=%h deb1=%b required all 0",
                     debounced, rise, fall, state_dbg, debounced1);
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            n_cmp++;
            if ({debounced, rise, fall} !== {(j >= 8) ? 4'b1111 : 4'b0000,
                                             (j == 8) ? 4'b1111 : 4'b0000, 4'b0000}) begin
                n_err++;
                $display("FAIL post_reset tick %0d: deb=%b rise=%b fall=%b", j, debounced, rise, fall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        noisy[2] = 1'b0;
        test_toggle();
        test_back_to_back();
        test_min_count();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
